// File: rtl/display_mem_arbiter_if.sv
// rtl/display_mem_arbiter_if.sv - scanout read, writer and display memory signals of the arbiter
interface display_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // slave is the arbiter's view; master is the requesters plus the RAM
  modport slave (
    input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output rd_data, rd_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  rd_data, rd_valid, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/display_mem_arbiter.sv
// rtl/display_mem_arbiter.sv - single-port display RAM arbiter: scanout reads win, buffered writes
// drain in idle cycles (only in vertical blanking when TEAR_FREE is set)
module display_mem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TEAR_FREE  = 1
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         de,
  input  logic                         vsync,
  display_mem_arbiter_if.slave         bus,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         commit_done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {WAIT_SYNC, VBLANK, SCAN} state_t;

  state_t                     state, state_nxt;
  logic                       vsync_q;
  logic                       vsync_fall;
  logic                       commit_nxt;
  logic                       window;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [ADDR_W+DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [ADDR_W+DATA_W-1:0]   head;
  logic [1:0]                 rd_pipe;

  // vsync is active-low, so the falling edge marks the start of vertical blanking
  assign vsync_fall = vsync_q & ~vsync;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= WAIT_SYNC;
      commit_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      commit_done <= commit_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    commit_nxt = 1'b0;
    case (state)
      WAIT_SYNC: if (vsync_fall) state_nxt = VBLANK;
      VBLANK: begin
        if (de) begin
          state_nxt  = SCAN;
          commit_nxt = (fifo_level == '0);
        end
      end
      SCAN:      if (vsync_fall) state_nxt = VBLANK;
      default:   state_nxt = WAIT_SYNC;
    endcase
  end

  assign window       = (TEAR_FREE != 0) ? (state == VBLANK) : (state != WAIT_SYNC);
  assign fifo_empty   = (fifo_level == '0);
  assign bus.wr_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
  assign push         = bus.wr_valid & bus.wr_ready;
  // a read in the same cycle always takes the memory slot, so the write stays queued
  assign pop          = ~bus.rd_req & window & ~fifo_empty;
  assign head         = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.wr_addr, bus.wr_data};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (bus.rd_req) begin
      bus.mem_en    <= 1'b1;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= bus.rd_addr;
    end else if (pop) begin
      bus.mem_en    <= 1'b1;
      bus.mem_we    <= 1'b1;
      bus.mem_addr  <= head[ADDR_W+DATA_W-1:DATA_W];
      bus.mem_wdata <= head[DATA_W-1:0];
    end else begin
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
    end
  end

  // one stage for the registered address, one for the RAM's synchronous read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_pipe <= 2'b00;
    end else begin
      rd_pipe <= {rd_pipe[0], bus.rd_req};
    end
  end

  assign bus.rd_valid = rd_pipe[1];
  assign bus.rd_data  = bus.mem_rdata;
endmodule

// File: tb/tb_display_mem_arbiter.sv
// tb/tb_display_mem_arbiter.sv - directed bench: tear-free and free-running arbiters side by side
module tb_display_mem_arbiter;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          de = 1'b0;
    logic          vsync = 1'b1;
    logic          rd_req = 1'b0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    lvl_a;
    logic [3:0]    lvl_b;
    logic          commit_a;
    logic          commit_b;
    logic [DW-1:0] ram [1024];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    display_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
    display_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();

    assign ia.rd_req   = rd_req;
    assign ia.rd_addr  = rd_addr;
    assign ia.wr_valid = wr_valid;
    assign ia.wr_addr  = wr_addr;
    assign ia.wr_data  = wr_data;
    assign ib.rd_req   = rd_req;
    assign ib.rd_addr  = rd_addr;
    assign ib.wr_valid = wr_valid;
    assign ib.wr_addr  = wr_addr;
    assign ib.wr_data  = wr_data;
    assign ib.mem_rdata = '0;

    always @(posedge clk) begin
        if (ia.mem_en) begin
            if (ia.mem_we) ram[ia.mem_addr] <= ia.mem_wdata;
            else           ia.mem_rdata <= ram[ia.mem_addr];
        end
    end

    display_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TEAR_FREE(1)) u_tf (
        .clk(clk), .resetn(resetn), .de(de), .vsync(vsync), .bus(ia.slave),
        .fifo_level(lvl_a), .commit_done(commit_a)
    );

    display_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .TEAR_FREE(0)) u_nt (
        .clk(clk), .resetn(resetn), .de(de), .vsync(vsync), .bus(ib.slave),
        .fifo_level(lvl_b), .commit_done(commit_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        check("rst_en", ia.mem_en, 1'b0);
        check("rst_we", ia.mem_we, 1'b0);
        check("rst_addr", ia.mem_addr, 10'h000);
        check("rst_wdata", ia.mem_wdata, 8'h00);
        check("rst_rd_valid", ia.rd_valid, 1'b0);
        check("rst_level", lvl_a, 4'd0);
        check("rst_commit", commit_a, 1'b0);
        check("rst_wr_ready", ia.wr_ready, 1'b1);
        resetn = 1'b1;
        tick();

        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = AW'(32'h10 + i);
            wr_data = DW'(32'hA0 + i);
            tick();
        end
        wr_valid = 1'b0;
        check("ws_level", lvl_a, 4'd3);
        check("ws_level_nt", lvl_b, 4'd3);
        check("ws_wr_ready", ia.wr_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ws_no_we", ia.mem_we, 1'b0);
            check("ws_no_we_nt", ib.mem_we, 1'b0);
        end

        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        check("vb_edge_we", ia.mem_we, 1'b0);
        tick();
        check("vb_w0_we", ia.mem_we, 1'b1);
        check("vb_w0_addr", ia.mem_addr, 10'h010);
        check("vb_w0_data", ia.mem_wdata, 8'hA0);
        check("vb_w0_level", lvl_a, 4'd2);
        tick();
        check("vb_w1_addr", ia.mem_addr, 10'h011);
        tick();
        check("vb_w2_addr", ia.mem_addr, 10'h012);
        check("vb_w2_data", ia.mem_wdata, 8'hA2);
        check("vb_w2_level", lvl_a, 4'd0);
        tick();
        check("vb_idle_en", ia.mem_en, 1'b0);
        check("vb_idle_we", ia.mem_we, 1'b0);
        check("vb_idle_addr_hold", ia.mem_addr, 10'h012);
        check("vb_no_commit", commit_a, 1'b0);
        de = 1'b1;
        tick();
        check("commit_pulse", commit_a, 1'b1);
        check("commit_pulse_nt", commit_b, 1'b1);
        tick();
        check("commit_once", commit_a, 1'b0);

        wr_valid = 1'b1;
        wr_addr = 10'h005;
        wr_data = 8'h31;
        tick();
        wr_addr = 10'h006;
        wr_data = 8'h32;
        tick();
        wr_valid = 1'b0;
        check("scan_level", lvl_a, 4'd2);
        check("nt_w0_we", ib.mem_we, 1'b1);
        check("nt_w0_addr", ib.mem_addr, 10'h005);
        tick();
        check("nt_w1_addr", ib.mem_addr, 10'h006);
        check("nt_w1_data", ib.mem_wdata, 8'h32);
        check("nt_level", lvl_b, 4'd0);
        for (int i = 0; i < 3; i++) begin
            check("scan_no_we", ia.mem_we, 1'b0);
            tick();
        end
        check("scan_level_hold", lvl_a, 4'd2);

        de = 1'b0;
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        rd_req = 1'b1;
        rd_addr = 10'h010;
        tick();
        check("rd0_en", ia.mem_en, 1'b1);
        check("rd0_we", ia.mem_we, 1'b0);
        check("rd0_addr", ia.mem_addr, 10'h010);
        check("rd0_level", lvl_a, 4'd2);
        rd_addr = 10'h011;
        tick();
        rd_req = 1'b0;
        check("rd1_we", ia.mem_we, 1'b0);
        check("rd1_addr", ia.mem_addr, 10'h011);
        check("rd0_valid", ia.rd_valid, 1'b1);
        check("rd0_data", ia.rd_data, 8'hA0);
        tick();
        check("defer_we", ia.mem_we, 1'b1);
        check("defer_addr", ia.mem_addr, 10'h005);
        check("defer_data", ia.mem_wdata, 8'h31);
        check("rd1_valid", ia.rd_valid, 1'b1);
        check("rd1_data", ia.rd_data, 8'hA1);
        tick();
        check("defer2_addr", ia.mem_addr, 10'h006);
        check("defer2_level", lvl_a, 4'd0);
        check("rd_valid_end", ia.rd_valid, 1'b0);
        tick();
        check("defer_idle", ia.mem_en, 1'b0);
        de = 1'b1;
        tick();
        tick();

        wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = AW'(32'h20 + i);
            wr_data = DW'(32'h40 + i);
            tick();
        end
        check("full_level", lvl_a, 4'd8);
        check("full_wr_ready", ia.wr_ready, 1'b0);
        wr_addr = 10'h3FF;
        wr_data = 8'hEE;
        tick();
        check("full_ignored", lvl_a, 4'd8);
        de = 1'b0;
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        check("full_vb_level", lvl_a, 4'd8);
        tick();
        check("pop_level", lvl_a, 4'd7);
        check("pop_addr", ia.mem_addr, 10'h020);
        check("pop_data", ia.mem_wdata, 8'h40);
        tick();
        wr_valid = 1'b0;
        check("pushpop_level", lvl_a, 4'd7);
        check("pushpop_addr", ia.mem_addr, 10'h021);
        for (int i = 2; i < 8; i++) begin
            tick();
            check("order_addr", ia.mem_addr, AW'(32'h20 + i));
            check("order_data", ia.mem_wdata, DW'(32'h40 + i));
        end
        tick();
        check("late_addr", ia.mem_addr, 10'h3FF);
        check("late_data", ia.mem_wdata, 8'hEE);
        check("late_level", lvl_a, 4'd0);
        tick();
        check("late_idle", ia.mem_we, 1'b0);
        de = 1'b1;
        tick();
        check("commit_pulse2", commit_a, 1'b1);
        tick();

        for (int i = 0; i < 8; i++) begin
            rd_req = (i % 2 == 0);
            rd_addr = AW'(32'h200 + i);
            wr_valid = (i < 4);
            wr_addr = AW'(32'h40 + i);
            wr_data = DW'(32'h60 + i);
            tick();
            if (i % 2 == 0) begin
                check("gap_rd_en", ib.mem_en, 1'b1);
                check("gap_rd_we", ib.mem_we, 1'b0);
                check("gap_rd_addr", ib.mem_addr, AW'(32'h200 + i));
            end else begin
                check("gap_wr_we", ib.mem_we, 1'b1);
                check("gap_wr_addr", ib.mem_addr, AW'(32'h40 + i / 2));
                check("gap_wr_data", ib.mem_wdata, DW'(32'h60 + i / 2));
            end
        end
        rd_req = 1'b0;
        wr_valid = 1'b0;
        tick();
        check("gap_idle", ib.mem_en, 1'b0);
        check("gap_level_nt", lvl_b, 4'd0);
        check("gap_level_tf", lvl_a, 4'd4);

        de = 1'b0;
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        rd_req = 1'b1;
        rd_addr = 10'h010;
        tick();
        rd_req = 1'b0;
        check("pre_rst_en", ia.mem_en, 1'b1);
        check("pre_rst_level", lvl_a, 4'd4);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_en", ia.mem_en, 1'b0);
        check("arst_addr", ia.mem_addr, 10'h000);
        check("arst_level", lvl_a, 4'd0);
        check("arst_rd_valid", ia.rd_valid, 1'b0);
        tick();
        check("arst_rd_valid2", ia.rd_valid, 1'b0);
        resetn = 1'b1;
        wr_valid = 1'b1;
        wr_addr = 10'h050;
        wr_data = 8'h70;
        tick();
        wr_valid = 1'b0;
        check("post_rst_rd_valid", ia.rd_valid, 1'b0);
        check("post_rst_level", lvl_a, 4'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_we", ia.mem_we, 1'b0);
            check("post_rst_no_we_nt", ib.mem_we, 1'b0);
        end
        check("post_rst_wait_sync", lvl_a, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
